// File: rtl/dmem_ctrl.sv
// dmem_ctrl: bridges the zero-latency data port of a single-cycle MIPS core to a
// variable-latency req/ack data memory. The core is frozen with cpu_stall until the
// access finishes; misaligned accesses and bus timeouts are aborted and flagged on a
// sticky err bit, and acknowledged transactions are counted.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-low reset
//   cpu_addr   in   byte address from the core (aluout)
//   cpu_wdata  in   store data (writedata)
//   cpu_we     in   store request (memwrite)
//   cpu_re     in   load request (memtoreg)
//   cpu_rdata  out  registered load data to the core (readdata)
//   cpu_stall  out  combinational freeze of core PC/regfile
//   mem_req    out  registered memory request
//   mem_we     out  registered write strobe, 1 = write
//   mem_addr   out  registered word-aligned address
//   mem_wdata  out  registered write data
//   mem_ack    in   one-cycle completion, only meaningful while mem_req = 1
//   mem_rdata  in   read data, valid with mem_ack on reads
//   err        out  sticky error: misaligned access or timeout
//   txn_count  out  count of acknowledged transactions, wraps at 16 bits
module dmem_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CW       = 4,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Last BUSY cycle index before the access is abandoned.
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          err_q, err_d;
  logic [15:0]   txn_count_q, txn_count_d;

  logic rq;

  // A simultaneous load+store request is treated as a store.
  assign rq = cpu_we | cpu_re;

  // The DONE cycle is the one cycle in which the core is allowed to commit.
  assign cpu_stall = rq & (state_q != StDone);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    err_d       = err_q;
    txn_count_d = txn_count_q;

    unique case (state_q)
      StIdle: begin
        if (rq) begin
          if (cpu_addr[1:0] == 2'b00) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_we_d    = cpu_we;
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            state_d     = StBusy;
          end else begin
            // Misaligned: never touch memory, complete with an error.
            err_d = 1'b1;
            if (!cpu_we) begin
              cpu_rdata_d = ERR_DATA;
            end
            state_d = StDone;
          end
        end
      end

      StBusy: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end
          txn_count_d = txn_count_q + 16'd1;
          state_d     = StDone;
        end else if (cnt_q == CntLast) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (!mem_we_q) begin
            cpu_rdata_d = ERR_DATA;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      err_q       <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign err       = err_q;
  assign txn_count = txn_count_q;

endmodule
